// File: rtl/reg_manager_if.sv
// Issue, operand, write-back and status signals of reg_manager.
// The sb_err flag is present only when REG_MANAGER_SB_ERR_EN is defined.
interface reg_manager_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            iss_v;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic [4:0]      iss_rd;
  logic            iss_use_rs1;
  logic            iss_use_rs2;
  logic            iss_wr_rd;
  logic            iss_ok;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] wb_result;
  logic [4:0]      wb_rd;
  logic            wb_v;
  logic            pend_any;
`ifdef REG_MANAGER_SB_ERR_EN
  logic            sb_err;
`endif

  modport master (
`ifdef REG_MANAGER_SB_ERR_EN
    input  sb_err,
`endif
    output flush, iss_v, iss_rs1, iss_rs2, iss_rd, iss_use_rs1, iss_use_rs2,
           iss_wr_rd, wb_result, wb_rd, wb_v,
    input  iss_ok, rs1_data, rs2_data, pend_any
  );

  modport slave (
`ifdef REG_MANAGER_SB_ERR_EN
    output sb_err,
`endif
    input  flush, iss_v, iss_rs1, iss_rs2, iss_rd, iss_use_rs1, iss_use_rs2,
           iss_wr_rd, wb_result, wb_rd, wb_v,
    output iss_ok, rs1_data, rs2_data, pend_any
  );
endinterface

// File: rtl/reg_manager.sv
// Register file with per-register pending-write scoreboard, write-back bypass and flush.
// Optional sticky sb_err flag enabled by defining REG_MANAGER_SB_ERR_EN.
module reg_manager #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PEND_W = 2
) (
  input logic         clk,
  input logic         rst,
  reg_manager_if.slave bus
);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]   regs [32];
  logic [PEND_W-1:0] cnt  [32];
  logic [31:0]       inc_v;
  logic [31:0]       dec_v;
  logic              src1_rdy;
  logic              src2_rdy;
  logic              dst_ok;
  logic              iss_ok_w;
  logic              pend_any_w;

  always_comb begin
    if (bus.wb_v && bus.wb_rd == bus.iss_rs1 && bus.iss_rs1 != 5'd0)
      bus.rs1_data = bus.wb_result;
    else if (bus.iss_rs1 == 5'd0)
      bus.rs1_data = '0;
    else
      bus.rs1_data = regs[bus.iss_rs1];

    if (bus.wb_v && bus.wb_rd == bus.iss_rs2 && bus.iss_rs2 != 5'd0)
      bus.rs2_data = bus.wb_result;
    else if (bus.iss_rs2 == 5'd0)
      bus.rs2_data = '0;
    else
      bus.rs2_data = regs[bus.iss_rs2];
  end

  // A single outstanding write retiring this cycle releases the source.
  always_comb begin
    src1_rdy = !bus.iss_use_rs1 || bus.iss_rs1 == 5'd0 || cnt[bus.iss_rs1] == '0 ||
               (cnt[bus.iss_rs1] == PEND_W'(1) && bus.wb_v && bus.wb_rd == bus.iss_rs1);
    src2_rdy = !bus.iss_use_rs2 || bus.iss_rs2 == 5'd0 || cnt[bus.iss_rs2] == '0 ||
               (cnt[bus.iss_rs2] == PEND_W'(1) && bus.wb_v && bus.wb_rd == bus.iss_rs2);
    dst_ok   = !bus.iss_wr_rd || bus.iss_rd == 5'd0 || cnt[bus.iss_rd] != CNT_MAX ||
               (bus.wb_v && bus.wb_rd == bus.iss_rd);
    iss_ok_w = bus.iss_v && !bus.flush && !rst && src1_rdy && src2_rdy && dst_ok;
  end

  assign bus.iss_ok = iss_ok_w;

  always_comb begin
    inc_v      = '0;
    dec_v      = '0;
    pend_any_w = 1'b0;
    for (int unsigned r = 1; r < 32; r++) begin
      inc_v[r] = iss_ok_w && bus.iss_wr_rd && bus.iss_rd == r[4:0];
      dec_v[r] = bus.wb_v && bus.wb_rd == r[4:0] && cnt[r[4:0]] != '0;
      if (cnt[r[4:0]] != '0)
        pend_any_w = 1'b1;
    end
  end

  assign bus.pend_any = pend_any_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < 32; r++)
        regs[r[4:0]] <= '0;
    end else if (bus.wb_v && bus.wb_rd != 5'd0) begin
      regs[bus.wb_rd] <= bus.wb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int unsigned r = 0; r < 32; r++)
        cnt[r[4:0]] <= '0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (inc_v[r] && !dec_v[r])
          cnt[r[4:0]] <= cnt[r[4:0]] + PEND_W'(1);
        else if (dec_v[r] && !inc_v[r])
          cnt[r[4:0]] <= cnt[r[4:0]] - PEND_W'(1);
      end
    end
  end

`ifdef REG_MANAGER_SB_ERR_EN
  logic flush_q;
  logic sb_err_q;

  // Write-backs landing just after a flush are expected to be unmatched.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q  <= 1'b0;
      sb_err_q <= 1'b0;
    end else begin
      flush_q <= bus.flush;
      if (bus.wb_v && bus.wb_rd != 5'd0 && cnt[bus.wb_rd] == '0 && !bus.flush && !flush_q)
        sb_err_q <= 1'b1;
    end
  end

  assign bus.sb_err = sb_err_q;
`endif
endmodule

// File: tb/tb_reg_manager.sv
// Self-checking bench for reg_manager: directed scenarios then random traffic
// against a behavioural register/scoreboard model.
module tb_reg_manager;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned PEND_W = 2;
  localparam int          MAXC   = (1 << PEND_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_manager_if #(.XLEN(XLEN)) bus ();

  reg_manager #(.XLEN(XLEN), .PEND_W(PEND_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [XLEN-1:0] rf_m [32];
  int              cnt_m [32];
  bit              sb_m;
  bit              flush_prev_m;

  logic            obs_ok;
  logic [XLEN-1:0] obs_rs1;
  logic [XLEN-1:0] obs_rs2;
  logic            obs_pend;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit src_ready(input bit use_rs, input int rs);
    return !use_rs || rs == 0 || cnt_m[rs] == 0 ||
           (cnt_m[rs] == 1 && bus.wb_v && int'(bus.wb_rd) == rs);
  endfunction

  function automatic logic [XLEN-1:0] read_exp(input int rs);
    if (rs != 0 && bus.wb_v && int'(bus.wb_rd) == rs) return bus.wb_result;
    return (rs == 0) ? '0 : rf_m[rs];
  endfunction

  function automatic bit any_pending();
    for (int r = 0; r < 32; r++)
      if (cnt_m[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      rf_m[r]  = '0;
      cnt_m[r] = 0;
    end
    sb_m         = 1'b0;
    flush_prev_m = 1'b0;
  endtask

  task automatic idle();
    bus.flush       = 1'b0;
    bus.iss_v       = 1'b0;
    bus.iss_rs1     = 5'd0;
    bus.iss_rs2     = 5'd0;
    bus.iss_rd      = 5'd0;
    bus.iss_use_rs1 = 1'b0;
    bus.iss_use_rs2 = 1'b0;
    bus.iss_wr_rd   = 1'b0;
    bus.wb_v        = 1'b0;
    bus.wb_rd       = 5'd0;
    bus.wb_result   = '0;
  endtask

  // Inputs are already applied (1 time unit after a posedge); check mid-cycle, then advance.
  task automatic step();
    bit              e_ok;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    bit              e_pend;
    int              wrd;
    e_ok = bus.iss_v && !bus.flush && !rst &&
           src_ready(bus.iss_use_rs1, int'(bus.iss_rs1)) &&
           src_ready(bus.iss_use_rs2, int'(bus.iss_rs2)) &&
           (!bus.iss_wr_rd || bus.iss_rd == 5'd0 || cnt_m[bus.iss_rd] != MAXC ||
            (bus.wb_v && bus.wb_rd == bus.iss_rd));
    e1     = read_exp(int'(bus.iss_rs1));
    e2     = read_exp(int'(bus.iss_rs2));
    e_pend = any_pending();
    #4;
    obs_ok   = bus.iss_ok;
    obs_rs1  = bus.rs1_data;
    obs_rs2  = bus.rs2_data;
    obs_pend = bus.pend_any;
    check_eq("iss_ok", 64'(obs_ok), 64'(e_ok));
    check_eq("rs1_data", 64'(obs_rs1), 64'(e1));
    check_eq("rs2_data", 64'(obs_rs2), 64'(e2));
    check_eq("pend_any", 64'(obs_pend), 64'(e_pend));
`ifdef REG_MANAGER_SB_ERR_EN
    check_eq("sb_err", 64'(bus.sb_err), 64'(sb_m));
`endif
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      wrd = int'(bus.wb_rd);
      if (bus.wb_v && wrd != 0) begin
        if (cnt_m[wrd] == 0 && !bus.flush && !flush_prev_m) sb_m = 1'b1;
        rf_m[wrd] = bus.wb_result;
      end
      if (bus.flush) begin
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      end else begin
        if (bus.wb_v && wrd != 0 && cnt_m[wrd] > 0) cnt_m[wrd]--;
        if (e_ok && bus.iss_wr_rd && bus.iss_rd != 5'd0) cnt_m[bus.iss_rd]++;
      end
      flush_prev_m = bus.flush;
    end
    #1;
  endtask

  initial begin
    idle();
    model_clear();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Reset state: every register reads zero, nothing pending, sourceless issue accepted.
    for (int i = 1; i < 32; i++) begin
      bus.iss_rs1 = 5'(i);
      bus.iss_rs2 = 5'(32 - i);
      bus.iss_v   = 1'b1;
      step();
      check_eq("reset_rd", 64'(obs_rs1), 64'd0);
    end
    check_eq("reset_issue", 64'(obs_ok), 64'd1);
    check_eq("reset_pend", 64'(obs_pend), 64'd0);
    idle();

    // RAW stall, then release by same-cycle write-back with bypass.
    bus.iss_v = 1'b1; bus.iss_wr_rd = 1'b1; bus.iss_rd = 5'd5;
    step();
    check_eq("raw_first", 64'(obs_ok), 64'd1);
    bus.iss_wr_rd = 1'b0; bus.iss_use_rs1 = 1'b1; bus.iss_rs1 = 5'd5;
    step();
    check_eq("raw_stall", 64'(obs_ok), 64'd0);
    bus.wb_v = 1'b1; bus.wb_rd = 5'd5; bus.wb_result = 32'hDEADBEEF;
    step();
    check_eq("raw_release", 64'(obs_ok), 64'd1);
    check_eq("raw_bypass", 64'(obs_rs1), 64'hDEADBEEF);
    bus.wb_v = 1'b0; bus.iss_v = 1'b0;
    step();
    check_eq("raw_regfile", 64'(obs_rs1), 64'hDEADBEEF);
    idle();

    // Counter saturation on x7.
    bus.iss_v = 1'b1; bus.iss_wr_rd = 1'b1; bus.iss_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("sat_accept", 64'(obs_ok), 64'd1);
    end
    step();
    check_eq("sat_stall", 64'(obs_ok), 64'd0);
    bus.wb_v = 1'b1; bus.wb_rd = 5'd7; bus.wb_result = 32'h0000_0077;
    step();
    check_eq("sat_retry_wb", 64'(obs_ok), 64'd1);
    bus.wb_v = 1'b0;
    step();
    check_eq("sat_still_full", 64'(obs_ok), 64'd0);
    bus.iss_v = 1'b0; bus.wb_v = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle();
    step();
    check_eq("sat_drained", 64'(obs_pend), 64'd0);

    // x0 is never written and never pending.
    bus.wb_v = 1'b1; bus.wb_rd = 5'd0; bus.wb_result = 32'h1234;
    step();
    check_eq("x0_bypass", 64'(obs_rs1), 64'd0);
    idle();
    bus.iss_v = 1'b1; bus.iss_wr_rd = 1'b1; bus.iss_rd = 5'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("x0_issue", 64'(obs_ok), 64'd1);
      check_eq("x0_pend", 64'(obs_pend), 64'd0);
    end
    idle();

    // Flush drops reservations; late write-back still lands.
    bus.iss_v = 1'b1; bus.iss_wr_rd = 1'b1; bus.iss_rd = 5'd3;
    step();
    bus.iss_rd = 5'd4;
    step();
    bus.flush = 1'b1; bus.iss_rd = 5'd6;
    step();
    check_eq("flush_block", 64'(obs_ok), 64'd0);
    idle();
    step();
    check_eq("flush_pend", 64'(obs_pend), 64'd0);
    bus.wb_v = 1'b1; bus.wb_rd = 5'd3; bus.wb_result = 32'h55;
    step();
    idle();
    bus.iss_rs1 = 5'd3;
    step();
    check_eq("flush_late_wb", 64'(obs_rs1), 64'h55);
    check_eq("flush_late_pend", 64'(obs_pend), 64'd0);
`ifdef REG_MANAGER_SB_ERR_EN
    check_eq("flush_sb_err", 64'(bus.sb_err), 64'd1);
`endif
    idle();

    // Simultaneous increment and decrement leave x9 at one.
    bus.iss_v = 1'b1; bus.iss_wr_rd = 1'b1; bus.iss_rd = 5'd9;
    step();
    bus.wb_v = 1'b1; bus.wb_rd = 5'd9; bus.wb_result = 32'h99;
    step();
    check_eq("incdec_ok", 64'(obs_ok), 64'd1);
    idle();
    step();
    check_eq("incdec_pend", 64'(obs_pend), 64'd1);
    bus.wb_v = 1'b1; bus.wb_rd = 5'd9;
    step();
    idle();
    step();
    check_eq("incdec_drain", 64'(obs_pend), 64'd0);

    // Random traffic concentrated on a few registers to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      bus.flush       = ($urandom_range(0, 24) == 0);
      bus.iss_v       = $urandom_range(0, 3) != 0;
      bus.iss_rs1     = 5'($urandom_range(0, 7));
      bus.iss_rs2     = 5'($urandom_range(0, 7));
      bus.iss_rd      = 5'($urandom_range(0, 7));
      bus.iss_use_rs1 = 1'($urandom_range(0, 1));
      bus.iss_use_rs2 = 1'($urandom_range(0, 1));
      bus.iss_wr_rd   = $urandom_range(0, 3) != 0;
      bus.wb_v        = 1'($urandom_range(0, 1));
      bus.wb_rd       = 5'($urandom_range(0, 7));
      bus.wb_result   = $urandom;
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/reg_manager.md
Name: reg_manager

Overview:
- Architectural register file plus scoreboard. Sits directly downstream of write_back: it consumes the single committed result/rd/result_v stream from write_back.
- Supplies operands to the issue stage, with bypass of a same-cycle write-back.
- Tracks outstanding writes per register with small counters. Issue stalls on RAW hazards and on counter overflow.
- Supports a pipeline flush that drops all outstanding reservations.

Parameters:
- XLEN, 32, data width of registers and results.
- PEND_W, 2, width of each per-register pending counter (max outstanding writes = 2^PEND_W-1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  drop all pending reservations (branch/exception redirect).
- iss_v  in  1  issue stage presents an instruction.
- iss_rs1  in  5  source 1 index.
- iss_rs2  in  5  source 2 index.
- iss_rd  in  5  destination index.
- iss_use_rs1  in  1  instruction reads rs1.
- iss_use_rs2  in  1  instruction reads rs2.
- iss_wr_rd  in  1  instruction writes rd.
- iss_ok  out  1  instruction accepted this cycle.
- rs1_data  out  XLEN  operand 1.
- rs2_data  out  XLEN  operand 2.
- wb_result  in  XLEN  write_back result.
- wb_rd  in  5  write_back destination.
- wb_v  in  1  write_back result valid.
- pend_any  out  1  some register has pending count != 0 (used by fence/CSR serialisation).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high. On rst: all 32 registers = 0, all counters = 0, optional error flag = 0. Reset has priority over flush, write-back and issue in the same cycle.
- x0 handling: x0 reads 0, x0 writes are ignored, and x0 is never pending.
- Reads are combinational, zero latency.
  - rsN_data = wb_result when wb_v && wb_rd==rsN && rsN!=0 (bypass).
  - Otherwise rsN_data = regfile[rsN].
- Write: when wb_v && wb_rd!=0, the register is updated at the clk edge with wb_result. This holds even when flush is asserted, because committed results are never lost.
- Source ready, for N=1,2: !iss_use_rsN || rsN==0 || cnt[rsN]==0 || (cnt[rsN]==1 && wb_v && wb_rd==rsN).
- Destination ok: !iss_wr_rd || iss_rd==0 || cnt[rd]!=MAX || (wb_v && wb_rd==iss_rd).
- iss_ok = iss_v && !flush && !rst && src1 ready && src2 ready && destination ok. iss_ok is combinational.
- Counter update, per register r!=0, evaluated each cycle:
  - inc = iss_ok && iss_wr_rd && iss_rd==r.
  - dec = wb_v && wb_rd==r && cnt[r]!=0.
  - inc && dec: counter unchanged.
  - inc only: counter +1.
  - dec only: counter -1.
  - Counters never wrap: the MAX stall guarantees this.
- Write-back to a register with cnt==0 (stale after flush): data is written, the counter stays 0.
- Flush: all counters = 0 at the next edge. iss_ok is forced 0 during the flush cycle. Any inc from that cycle is discarded.
- pend_any = OR of all cnt != 0. It is registered-state derived, so it goes to 0 the cycle after the last decrement or flush.

Optional Feature:
- Macro: REG_MANAGER_SB_ERR_EN.
- When defined:
  - Adds output sb_err (1 bit), a sticky flag cleared only by rst.
  - sb_err is set at the edge when wb_v && wb_rd!=0 && cnt[wb_rd]==0, and no flush occurred in the current or previous cycle.
  - Purpose: detect write-backs not matched to an issue reservation.
- When undefined: the port does not exist, and the condition is silently ignored (data is still written).

Test Plan:
- Reset: rst high 1 cycle, then read x1..x31 → all 0; pend_any=0; iss_ok=1 for any issue with no sources.
- RAW stall: issue rd=5 (iss_ok=1); next cycle issue rs1=5 → iss_ok=0. Then wb_v=1, wb_rd=5, wb_result=0xDEADBEEF in the same cycle → iss_ok=1 and rs1_data=0xDEADBEEF via bypass; the following cycle regfile[5] reads 0xDEADBEEF.
- Counter saturation (PEND_W=2):
  - Three issues to rd=7 are accepted. The fourth gets iss_ok=0.
  - The fourth retried with a simultaneous wb to 7 → accepted, cnt stays 3.
- x0: wb_v=1, wb_rd=0, wb_result=0x1234 → x0 still reads 0. Issue with rd=0 repeated 10 times → always iss_ok=1, pend_any=0.
- Flush:
  - Issue rd=3 and rd=4, then assert flush → iss_ok=0 that cycle, pend_any=0 next cycle.
  - A later wb to 3 with value 0x55 → regfile[3]=0x55, counter stays 0, and sb_err=1 when REG_MANAGER_SB_ERR_EN is defined.
- Simultaneous inc/dec: cnt[9]=1, issue rd=9 plus wb rd=9 in the same cycle → cnt[9] stays 1, pend_any stays 1.
